// File: rtl/mfp_multi_digit_seven_segment_display_pkg.sv
// Shared types and the hex glyph table for the multiplexed seven-segment driver.
//   seg_t          : 7-bit segment vector, gfedcba order
//   SEG_ALL_OFF_N  : active-low "all segments dark" pattern
//   hex_to_seg_n() : nibble -> active-low gfedcba glyph
package mfp_multi_digit_seven_segment_display_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_ALL_OFF_N = 7'h7F;

  function automatic seg_t hex_to_seg_n(input logic [3:0] hex);
    seg_t glyph;
    case (hex)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/mfp_single_digit_seven_segment_display.sv
// Single-digit hex to seven-segment decoder (purely combinational).
//   digit          in  [3:0] : hex nibble
//   seven_segments out [6:0] : active-low segments, gfedcba order
module mfp_single_digit_seven_segment_display
  import mfp_multi_digit_seven_segment_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seven_segments
);

  always_comb begin
    seven_segments = hex_to_seg_n(digit);
  end

endmodule

// File: rtl/mfp_multi_digit_seven_segment_display.sv
// Time-multiplexed N-digit seven-segment driver with PWM dimming, per-slot
// dead time, leading-zero blanking and per-frame input snapshotting.
//   clk, resetn        : clock, async active-low reset
//   digits  [4N-1:0]   : hex nibbles, nibble i -> digit i (digit N-1 is MSD)
//   dp_in   [N-1:0]    : decimal point per digit
//   digit_en[N-1:0]    : per-digit enable (disabled digits are never selected)
//   brightness[BW-1:0] : PWM duty, all-ones = always on, 0 = dark
//   blank_lz           : leading-zero blanking enable
//   seg[6:0], dp       : shared segment lines (gfedcba), polarity SEG_ACTIVE_LOW
//   sel[N-1:0]         : one-hot or all-off digit select, polarity SEL_ACTIVE_LOW
//   frame_start        : one-cycle pulse when the outputs first show digit 0
module mfp_multi_digit_seven_segment_display
  import mfp_multi_digit_seven_segment_display_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV_LOG2  = 10,
  parameter int BRIGHT_W       = 4,
  parameter int DEAD_CYCLES    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   sel,
  output logic                  frame_start
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(N_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = '1;
  localparam seg_t                SEG_IDLE    = {SEG_W{SEG_ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] SEL_IDLE    = {N_DIGITS{SEL_ACTIVE_LOW}};

  logic [SCAN_DIV_LOG2-1:0] slot_cnt;
  logic [IDX_W-1:0]         idx;
  logic                     primed;

  logic [4*N_DIGITS-1:0] snap_digits;
  logic [N_DIGITS-1:0]   snap_dp;
  logic [N_DIGITS-1:0]   snap_en;
  logic [BRIGHT_W-1:0]   snap_bright;
  logic                  snap_blank_lz;

  logic slot_end;
  logic frame_wrap;

  assign slot_end   = &slot_cnt;
  assign frame_wrap = slot_end && (idx == IDX_LAST);

  // Snapshot is taken on the edge that wraps idx to 0. It is also taken on
  // the very first edge after reset, so the first frame after reset is
  // driven by live inputs rather than by the zeroed snapshot (which would
  // otherwise keep the display dark for a whole frame).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      slot_cnt      <= '0;
      idx           <= '0;
      primed        <= 1'b0;
      snap_digits   <= '0;
      snap_dp       <= '0;
      snap_en       <= '0;
      snap_bright   <= '0;
      snap_blank_lz <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + SCAN_DIV_LOG2'(1);
      primed   <= 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (!primed || frame_wrap) begin
        snap_digits   <= digits;
        snap_dp       <= dp_in;
        snap_en       <= digit_en;
        snap_bright   <= brightness;
        snap_blank_lz <= blank_lz;
      end
    end
  end

  // Leading-zero blanking: scan from the MSD down; a digit stays blank until
  // a non-zero nibble or a set dp is found at or above it. Digit 0 never blanks.
  logic [N_DIGITS-1:0] lz_blank;

  always_comb begin
    logic seen;
    seen     = 1'b0;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      seen        = seen | (snap_digits[4*i +: 4] != 4'h0) | snap_dp[i];
      lz_blank[i] = snap_blank_lz && (i != 0) && !seen;
    end
  end

  logic [3:0] cur_nibble;
  seg_t       dec_seg_n;

  assign cur_nibble = snap_digits[{idx, 2'b00} +: 4];

  mfp_single_digit_seven_segment_display u_decoder (
    .digit          (cur_nibble),
    .seven_segments (dec_seg_n)
  );

  logic past_dead;

  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign past_dead = 1'b1;
  end else begin : g_dead
    assign past_dead = (slot_cnt >= SCAN_DIV_LOG2'(DEAD_CYCLES));
  end

  logic duty_ok;
  logic sel_on;
  logic show;

  // Duty compares the top BRIGHT_W bits of the slot counter, so each
  // brightness step is an equal fraction of the slot.
  assign duty_ok = (snap_bright == BRIGHT_FULL) ||
                   (slot_cnt[SCAN_DIV_LOG2-1 -: BRIGHT_W] < snap_bright);
  assign sel_on  = snap_en[idx] && past_dead && duty_ok;
  assign show    = sel_on && !lz_blank[idx];

  seg_t                seg_hi;
  logic                dp_hi;
  logic [N_DIGITS-1:0] sel_hi;

  always_comb begin
    seg_hi      = show ? ~dec_seg_n : '0;
    dp_hi       = show && snap_dp[idx];
    sel_hi      = '0;
    sel_hi[idx] = sel_on;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seg         <= SEG_IDLE;
      dp          <= SEG_ACTIVE_LOW;
      sel         <= SEL_IDLE;
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_hi ^ SEG_IDLE;
      dp          <= dp_hi ^ SEG_ACTIVE_LOW;
      sel         <= sel_hi ^ SEL_IDLE;
      frame_start <= primed && (slot_cnt == '0) && (idx == '0);
    end
  end

endmodule
